// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          FETCH_WIDTH  = 32;
  localparam int          FETCH_INST_W = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]  pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries for decode.
// A flush empties it on the same edge and wins over any push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC mux, PC hold control, single-outstanding
// imem request FSM and a small FIFO of {pc, inst} entries for decode.
//
// state  | meaning
// S_REQ  | may request; issue when FIFO has room and no redirect
// S_WAIT | one request granted, waiting for its rvalid
// S_DROP | redirected while waiting; swallow the stale response
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [WIDTH-1:0]  i_pc,
  output logic [WIDTH-1:0]  o_nxt_pc,
  output logic              o_pc_stall,
  input  logic              i_redirect,
  input  logic [WIDTH-1:0]  i_redirect_pc,
  output logic              o_imem_req,
  output logic [WIDTH-1:0]  o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [WIDTH-1:0]  o_inst_pc,
  input  logic              i_id_ready
);

  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [WIDTH-1:0] req_pc_q;
  logic             req;
  logic             accept;
  logic             push;
  entry_t           push_data;
  entry_t           head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  assign accept      = req && i_imem_gnt;
  assign o_imem_req  = req;
  assign o_imem_addr = i_pc;
  assign o_nxt_pc    = i_redirect ? i_redirect_pc : i_pc + WIDTH'(4);
  assign o_pc_stall  = !(i_redirect || accept);
  assign push_data   = '{pc: req_pc_q, inst: i_imem_rdata};

  assign o_inst_valid = !empty;
  assign o_inst       = empty ? INST_W'(INST_NOP) : head.inst;
  assign o_inst_pc    = empty ? '0 : head.pc;

  // State register plus the PC of the request currently in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_REQ;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) req_pc_q <= i_pc;
    end
  end

  // Next-state, request and push decode.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_REQ: begin
        req = (count < CW'(DEPTH)) && !i_redirect;
        if (req && i_imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          push    = !i_redirect;
          state_d = S_REQ;
        end else if (i_redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (i_imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // A request is only issued with room in the FIFO, so its response can never find it full.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(push && full));

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (i_id_ready),
    .flush     (i_redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, inst}
// into a queue; a monitor pops and compares whenever decode consumes an entry.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc;
  logic [31:0] o_nxt_pc;
  logic        o_pc_stall;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_id_ready = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;

  logic        auto_mem = 1'b0;
  int          budget = 0;
  logic        acc = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] pc_q;

  always #5 i_clk = ~i_clk;

  fetch_unit #(.WIDTH(32), .INST_W(32), .DEPTH(2)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pc          (i_pc),
    .o_nxt_pc      (o_nxt_pc),
    .o_pc_stall    (o_pc_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_id_ready    (i_id_ready)
  );

  // PC register around the fetch stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         pc_q <= '0;
    else if (!o_pc_stall) pc_q <= o_nxt_pc;
  end
  assign i_pc = pc_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Auto memory: record accepted requests mid-cycle, answer one cycle later.
  always @(negedge i_clk) begin
    if (auto_mem && i_rst_n && o_imem_req && i_imem_gnt) begin
      acc      = 1'b1;
      acc_addr = o_imem_addr;
      budget   = budget - 1;
    end else begin
      acc = 1'b0;
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (auto_mem) begin
      i_imem_rvalid = acc;
      i_imem_rdata  = 32'hDEAD_0000 ^ acc_addr;
      i_imem_gnt    = (budget > 0);
    end
  end

  // Monitor: every consumed entry must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (i_rst_n && o_inst_valid && i_id_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected no entry", o_inst_pc, o_inst);
      end else begin
        mon_e = exp_q.pop_front();
        check("inst_pc", o_inst_pc, mon_e.pc);
        check("inst_data", o_inst, mon_e.inst);
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) @(negedge i_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d entries left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    i_rst_n       = 1'b0;
    auto_mem      = 1'b0;
    budget        = 0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_id_ready    = 1'b0;
    @(negedge i_clk);
    check("rst_valid", o_inst_valid, 0);
    check("rst_inst", o_inst, 32'h0000_0013);
    check("rst_pc", o_inst_pc, 0);
    cyc();
    i_rst_n = 1'b1;
  endtask

  initial begin
    // 1: streaming fetch of 0,4,8
    do_reset();
    exp_q.push_back({32'h0, 32'hDEAD_0000});
    exp_q.push_back({32'h4, 32'hDEAD_0004});
    exp_q.push_back({32'h8, 32'hDEAD_0008});
    budget = 3; auto_mem = 1'b1; i_imem_gnt = 1'b1; i_id_ready = 1'b1;
    wait_drain("t1_drain", 30);
    repeat (3) @(negedge i_clk);
    check("t1_idle_valid", o_inst_valid, 0);

    // 2: decode stalled, FIFO fills to 2 then fetch stops; resume gives 8
    do_reset();
    exp_q.push_back({32'h0, 32'hDEAD_0000});
    exp_q.push_back({32'h4, 32'hDEAD_0004});
    exp_q.push_back({32'h8, 32'hDEAD_0008});
    budget = 3; auto_mem = 1'b1; i_imem_gnt = 1'b1; i_id_ready = 1'b0;
    repeat (8) @(negedge i_clk);
    check("t2_full_req", o_imem_req, 0);
    check("t2_full_stall", o_pc_stall, 1);
    check("t2_full_grants", budget, 1);
    check("t2_head_pc", o_inst_pc, 32'h0);
    cyc();
    i_id_ready = 1'b1;
    wait_drain("t2_drain", 30);

    // 3: redirect while waiting, stale response dropped
    do_reset();
    i_id_ready = 1'b1; i_imem_gnt = 1'b1;
    @(negedge i_clk);
    check("t3_req0", o_imem_req, 1);
    check("t3_addr0", o_imem_addr, 32'h0);
    cyc();
    i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h100;
    @(negedge i_clk);
    check("t3_redir_nxt", o_nxt_pc, 32'h100);
    check("t3_redir_stall", o_pc_stall, 0);
    check("t3_wait_req", o_imem_req, 0);
    cyc();
    i_redirect = 1'b0;
    @(negedge i_clk);
    check("t3_drop_req", o_imem_req, 0);
    cyc();
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_0000;
    @(negedge i_clk);
    check("t3_drop_req2", o_imem_req, 0);
    cyc();
    i_imem_rvalid = 1'b0; i_imem_gnt = 1'b1;
    exp_q.push_back({32'h100, 32'h1111_0100});
    @(negedge i_clk);
    check("t3_req_new", o_imem_req, 1);
    check("t3_addr_new", o_imem_addr, 32'h100);
    check("t3_no_stale", o_inst_valid, 0);
    cyc();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h1111_0100;
    cyc();
    i_imem_rvalid = 1'b0;
    wait_drain("t3_drain", 10);

    // 4: redirect together with rvalid while FIFO holds one entry
    do_reset();
    i_imem_gnt = 1'b1;
    cyc();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h2222_0000;
    cyc();
    i_imem_rvalid = 1'b0; i_imem_gnt = 1'b1;
    @(negedge i_clk);
    check("t4_one_valid", o_inst_valid, 1);
    check("t4_one_inst", o_inst, 32'h2222_0000);
    check("t4_req_addr", o_imem_addr, 32'h4);
    cyc();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h2222_0004;
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    cyc();
    i_imem_rvalid = 1'b0; i_redirect = 1'b0;
    @(negedge i_clk);
    check("t4_flush_valid", o_inst_valid, 0);
    check("t4_flush_inst", o_inst, 32'h0000_0013);
    check("t4_flush_pc", o_inst_pc, 0);
    check("t4_state_req", o_imem_req, 1);
    check("t4_addr", o_imem_addr, 32'h200);
    repeat (2) @(negedge i_clk);
    check("t4_no_push", o_inst_valid, 0);
    cyc();

    // 5: PC wraps at the top of the address space
    do_reset();
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    @(negedge i_clk);
    check("t5_redir_nxt", o_nxt_pc, 32'hFFFF_FFFC);
    check("t5_redir_req", o_imem_req, 0);
    cyc();
    i_redirect = 1'b0; i_imem_gnt = 1'b1;
    @(negedge i_clk);
    check("t5_addr", o_imem_addr, 32'hFFFF_FFFC);
    check("t5_wrap_nxt", o_nxt_pc, 32'h0);
    check("t5_stall", o_pc_stall, 0);
    cyc();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h3333_FFFC; i_id_ready = 1'b1;
    exp_q.push_back({32'hFFFF_FFFC, 32'h3333_FFFC});
    cyc();
    i_imem_rvalid = 1'b0;
    @(negedge i_clk);
    check("t5_pc_after", o_imem_addr, 32'h0);
    wait_drain("t5_drain", 10);

    // 6: reset while a request is outstanding
    do_reset();
    i_imem_gnt = 1'b1;
    cyc();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h4444_0000;
    cyc();
    i_imem_rvalid = 1'b0; i_imem_gnt = 1'b1;
    cyc();
    i_imem_gnt = 1'b0;
    @(negedge i_clk);
    check("t6_pre_valid", o_inst_valid, 1);
    check("t6_pre_req", o_imem_req, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", o_inst_valid, 0);
    check("t6_rst_inst", o_inst, 32'h0000_0013);
    check("t6_rst_pc", o_inst_pc, 0);
    cyc();
    i_rst_n = 1'b1; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h5555_0004; i_id_ready = 1'b1;
    cyc();
    i_imem_rvalid = 1'b0;
    @(negedge i_clk);
    check("t6_late_ignored", o_inst_valid, 0);
    check("t6_state_req", o_imem_req, 1);
    check("t6_addr", o_imem_addr, 32'h0);
    repeat (3) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
